// File: rtl/bsg_expand_bitmask_stream.sv
// Streams an in_width_p-bit mask, each bit replicated expand_p times, as out_width_p-bit chunks.
// Optional: BSG_EXPAND_BITMASK_STREAM_SKIP_ZERO_EN suppresses all-zero chunks.
module bsg_expand_bitmask_stream #(
  parameter int in_width_p  = 16,
  parameter int expand_p    = 32,
  parameter int out_width_p = 64,
  localparam int els_lp   = in_width_p*expand_p/out_width_p,
  localparam int idx_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [in_width_p-1:0]  data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [out_width_p-1:0] data_o,
  output logic [idx_w_lp-1:0]    idx_o,
  output logic                   last_o,
  input  logic                   yumi_i
);

  // Handshakes: a mask transfers on a clock edge where v_i & ready_o; a chunk
  // is consumed on an edge where yumi_i, which the consumer may raise only while v_o.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int full_w_lp = in_width_p*expand_p;

  state_t                  state_r, state_n;
  logic [in_width_p-1:0]   mask_r, mask_n;
  logic [idx_w_lp-1:0]     idx_r, idx_n;
  logic [idx_w_lp-1:0]     first_idx, next_idx;
  logic                    last_chunk, accept_ok;

  logic [full_w_lp-1:0]                  expanded;
  logic [els_lp-1:0][out_width_p-1:0]    chunks;

  for (genvar g = 0; g < in_width_p; g++) begin : g_rep
    assign expanded[g*expand_p +: expand_p] = {expand_p{mask_r[g]}};
  end
  assign chunks = expanded;

`ifdef BSG_EXPAND_BITMASK_STREAM_SKIP_ZERO_EN
  logic [full_w_lp-1:0]               expanded_in;
  logic [els_lp-1:0][out_width_p-1:0] chunks_in;
  logic [els_lp-1:0]                  nz_r, nz_in;
  logic                               more;

  for (genvar g = 0; g < in_width_p; g++) begin : g_rep_in
    assign expanded_in[g*expand_p +: expand_p] = {expand_p{data_i[g]}};
  end
  assign chunks_in = expanded_in;

  for (genvar c = 0; c < els_lp; c++) begin : g_nz
    assign nz_r[c]  = |chunks[c];
    assign nz_in[c] = |chunks_in[c];
  end

  // Downward scans so the lowest qualifying chunk wins.
  always_comb begin
    first_idx = '0;
    next_idx  = idx_r;
    more      = 1'b0;
    for (int c = els_lp-1; c >= 0; c--) begin
      if (nz_in[c]) first_idx = idx_w_lp'(c);
      if (nz_r[c] && (c > int'(idx_r))) begin
        next_idx = idx_w_lp'(c);
        more     = 1'b1;
      end
    end
  end
  assign last_chunk = ~more;
  assign accept_ok  = |nz_in;
`else
  assign first_idx  = '0;
  assign next_idx   = idx_r + idx_w_lp'(1);
  assign last_chunk = (idx_r == idx_w_lp'(els_lp-1));
  assign accept_ok  = 1'b1;
`endif

  always_comb begin
    state_n = state_r;
    mask_n  = mask_r;
    idx_n   = idx_r;
    case (state_r)
      IDLE: begin
        if (v_i && accept_ok) begin
          mask_n  = data_i;
          idx_n   = first_idx;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (yumi_i) begin
          if (last_chunk) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = next_idx;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      mask_r  <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_n;
      mask_r  <= mask_n;
      idx_r   <= idx_n;
    end
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == BUSY);
  assign data_o  = v_o ? chunks[idx_r] : '0;
  assign idx_o   = idx_r;
  assign last_o  = v_o & last_chunk;

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted without v_o");
      assert (((in_width_p*expand_p) % out_width_p) == 0 && els_lp >= 1)
        else $error("in_width_p*expand_p must be a nonzero multiple of out_width_p");
    end
  end

endmodule

// File: tb/tb_bsg_expand_bitmask_stream.sv
// Bench for bsg_expand_bitmask_stream (default build): vector table, directed corners, random masks.
module tb_bsg_expand_bitmask_stream;

  localparam int IN  = 16;
  localparam int EXP = 32;
  localparam int OUT = 64;
  localparam int ELS = IN*EXP/OUT;

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic            v_i;
  logic [IN-1:0]   data_i;
  logic            ready_o;
  logic            v_o;
  logic [OUT-1:0]  data_o;
  logic [2:0]      idx_o;
  logic            last_o;
  logic            yumi_i;

  int compared   = 0;
  int mismatched = 0;

  logic [OUT-1:0] exp_q[$];
  logic [OUT-1:0] got_q[$];

  always #5 clk = ~clk;

  bsg_expand_bitmask_stream #(.in_width_p(IN), .expand_p(EXP), .out_width_p(OUT)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .idx_o(idx_o), .last_o(last_o), .yumi_i(yumi_i)
  );

  // Reference: bit j of chunk c is mask bit floor((c*OUT + j)/EXP).
  function automatic logic [OUT-1:0] model_chunk(input logic [IN-1:0] m, input int c);
    logic [OUT-1:0] r;
    for (int j = 0; j < OUT; j++) r[j] = m[(c*OUT + j) / EXP];
    return r;
  endfunction

  task automatic check(input string name, input logic [OUT-1:0] act, input logic [OUT-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [IN-1:0] m);
    for (int c = 0; c < ELS; c++) exp_q.push_back(model_chunk(m, c));
  endtask

  task automatic send(input logic [IN-1:0] m);
    int t = 0;
    while (!ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", 64'(ready_o), 64'd1);
    v_i = 1'b1;
    data_i = m;
    push_expected(m);
    @(negedge clk);
    v_i = 1'b0;
  endtask

  // Consumes one full burst; optional stall of stall_len cycles at beat stall_idx.
  task automatic drain(input int stall_idx, input int stall_len);
    logic [OUT-1:0] exp_c, held_d;
    logic [2:0]     held_i;
    logic           held_l;
    for (int b = 0; b < ELS; b++) begin
      exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("beat_v_o", 64'(v_o), 64'd1);
      check("beat_idx", 64'(idx_o), 64'(b));
      check("beat_data", data_o, exp_c);
      check("beat_last", 64'(last_o), 64'(b == ELS-1));
      got_q.push_back(data_o);
      if (b == stall_idx) begin
        held_d = data_o; held_i = idx_o; held_l = last_o;
        for (int s = 0; s < stall_len; s++) begin
          yumi_i = 1'b0;
          @(negedge clk);
          check("stall_v_o", 64'(v_o), 64'd1);
          check("stall_data", data_o, held_d);
          check("stall_idx", 64'(idx_o), 64'(held_i));
          check("stall_last", 64'(last_o), 64'(held_l));
        end
      end
      yumi_i = v_o;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    check("post_ready", 64'(ready_o), 64'd1);
    check("post_v_o", 64'(v_o), 64'd0);
  endtask

  typedef struct {
    logic [IN-1:0]  mask;
    int             probe;
    logic [OUT-1:0] exp_chunk;
    int             stall_idx;
    int             stall_len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h0001, 0, 64'h0000_0000_FFFF_FFFF, -1, 0};
    vecs[1] = '{16'h0001, 1, 64'h0000_0000_0000_0000, -1, 0};
    vecs[2] = '{16'h8000, 7, 64'hFFFF_FFFF_0000_0000,  2, 3};
    vecs[3] = '{16'h5555, 3, 64'h0000_0000_FFFF_FFFF,  5, 1};
    vecs[4] = '{16'hAAAA, 6, 64'hFFFF_FFFF_0000_0000,  0, 2};
    vecs[5] = '{16'h0300, 4, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0};
    vecs[6] = '{16'h0C00, 5, 64'hFFFF_FFFF_FFFF_FFFF,  7, 2};
    vecs[7] = '{16'h0100, 4, 64'h0000_0000_FFFF_FFFF, -1, 0};

    reset_n_i = 1'b0; v_i = 1'b1; data_i = 16'hFFFF; yumi_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_idx", 64'(idx_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    reset_n_i = 1'b1; v_i = 1'b0;
    @(negedge clk);
    check("rst_nothing_accepted", 64'(v_o), 64'd0);

    foreach (vecs[k]) begin
      got_q.delete();
      send(vecs[k].mask);
      drain(vecs[k].stall_idx, vecs[k].stall_len);
      check($sformatf("vec%0d_probe", k),
            (got_q.size() == ELS) ? got_q[vecs[k].probe] : '0, vecs[k].exp_chunk);
    end

    // v_i held across a burst: second mask taken once ready_o returns.
    v_i = 1'b1; data_i = 16'hFFFF;
    push_expected(16'hFFFF);
    @(negedge clk);
    data_i = 16'h5555;
    drain(-1, 0);
    push_expected(16'h5555);
    @(negedge clk);
    v_i = 1'b0;
    drain(-1, 0);

    // Reset in the middle of a burst.
    send(16'hAAAA);
    for (int b = 0; b < 3; b++) begin
      void'(exp_q.pop_front());
      check("abort_idx", 64'(idx_o), 64'(b));
      yumi_i = v_o;
      @(negedge clk);
      yumi_i = 1'b0;
    end
    exp_q.delete();
    reset_n_i = 1'b0;
    @(negedge clk);
    check("abort_v_o", 64'(v_o), 64'd0);
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_idx0", 64'(idx_o), 64'd0);
    reset_n_i = 1'b1;
    send(16'h0001);
    drain(-1, 0);

    for (int r = 0; r < 20; r++) begin
      send(16'($urandom));
      drain($urandom_range(0, 9), $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule
